fetch_control: RTL and testbench

FETCH_CONTROL -- requirements
Module: fetch_control

---
 rtl/fetch_control_pkg.sv | 18 +
 rtl/fetch_next_pc.sv | 13 +
 rtl/fetch_control.sv | 112 +++++++++++
 tb/tb_fetch_control.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_control_pkg.sv
// fetch_control_pkg: state codes and opcodes shared by fetch control and the datapath (STATE_STEP exists only with FETCH_STEP_EN)
package fetch_control_pkg;
  typedef enum logic [3:0] {
    STATE_HLT    = 4'd0,
    STATE_FETCH0 = 4'd1,
    STATE_FETCH1 = 4'd2,
`ifdef FETCH_STEP_EN
    STATE_STEP   = 4'd4,
`endif
    STATE_EXEC   = 4'd3
  } state_t;
  localparam logic [7:0] OP_CP     = 8'h01;
  localparam logic [7:0] OP_LIMM32 = 8'h02;
  localparam logic [7:0] OP_END    = 8'hFF;
  function automatic logic is_op(input logic [31:0] w, input logic [7:0] op);
    return w[31:24] == op;
  endfunction
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: next pc after EXEC -- branch target, or pc+2 past a two-word opcode, else pc+1, wrapping mod 2^PC_W
module fetch_next_pc #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_limm,
  input  logic            i_jmp_en,
  input  logic [PC_W-1:0] i_jmp_addr,
  output logic [PC_W-1:0] o_next_pc
);
  // pick the successor address; the add truncates to PC_W bits so the pc wraps
  always_comb o_next_pc = i_jmp_en ? i_jmp_addr : i_pc + (i_limm ? PC_W'(2) : PC_W'(1));
endmodule

// File: rtl/fetch_control.sv
// fetch_control: instruction fetch sequencer (one- or two-word opcodes, halt, branch); FETCH_STEP_EN adds single-step
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter int            PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
`ifdef FETCH_STEP_EN
  input  logic            i_step,
`endif
  output logic [PC_W-1:0] o_imem_addr,
  output logic            o_imem_re,
  input  logic [31:0]     i_imem_data,
  input  logic            i_imem_valid,
  input  logic            i_jmp_en,
  input  logic [PC_W-1:0] i_jmp_addr,
  output logic [31:0]     o_instr0,
  output logic [31:0]     o_instr1,
  output logic [3:0]      o_current_state,
  output logic [PC_W-1:0] o_pc,
  output logic            o_halted
);
  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_imem_addr;
  logic            r_imem_re;
  logic [31:0]     r_instr0;
  logic [31:0]     r_instr1;
  logic            r_halted;
  logic [PC_W-1:0] w_next_pc;
  logic            w_leave;
  logic            w_is_end;
  logic            w_is_limm;

  assign w_is_end  = is_op(r_instr0, OP_END);
  assign w_is_limm = is_op(r_instr0, OP_LIMM32);
`ifdef FETCH_STEP_EN
  assign w_leave = (r_state == STATE_STEP) && i_step;
`else
  assign w_leave = r_state == STATE_EXEC;
`endif

  fetch_next_pc #(.PC_W(PC_W)) u_next_pc (
    .i_pc       (r_pc),
    .i_limm     (w_is_limm),
    .i_jmp_en   (i_jmp_en),
    .i_jmp_addr (i_jmp_addr),
    .o_next_pc  (w_next_pc)
  );

  // fetch FSM: raise a request one cycle after entering a fetch state, hold it until valid, then latch and move on
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= STATE_FETCH0;
      r_pc        <= RESET_PC;
      r_imem_addr <= RESET_PC;
      r_imem_re   <= 1'b0;
      r_instr0    <= '0;
      r_instr1    <= '0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        STATE_FETCH0, STATE_FETCH1: begin
          if (!r_imem_re) begin
            r_imem_re   <= 1'b1;
            r_imem_addr <= (r_state == STATE_FETCH1) ? r_pc + PC_W'(1) : r_pc;
          end else if (i_imem_valid) begin
            r_imem_re <= 1'b0;
            if (r_state == STATE_FETCH0) begin
              r_instr0 <= i_imem_data;
              r_instr1 <= '0;
              r_state  <= is_op(i_imem_data, OP_LIMM32) ? STATE_FETCH1 : STATE_EXEC;
            end else begin
              r_instr1 <= i_imem_data;
              r_state  <= STATE_EXEC;
            end
          end
        end
`ifdef FETCH_STEP_EN
        STATE_EXEC, STATE_STEP: begin
`else
        STATE_EXEC: begin
`endif
          if (w_leave) begin
            if (w_is_end) begin
              r_state  <= STATE_HLT;
              r_halted <= 1'b1;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= STATE_FETCH0;
            end
          end
`ifdef FETCH_STEP_EN
          else r_state <= STATE_STEP;
`endif
        end
        STATE_HLT: r_state <= STATE_HLT;
        default: r_state <= STATE_HLT;
      endcase
    end
  end

  assign o_imem_addr     = r_imem_addr;
  assign o_imem_re       = r_imem_re;
  assign o_instr0        = r_instr0;
  assign o_instr1        = r_instr1;
  assign o_current_state = r_state;
  assign o_pc            = r_pc;
  assign o_halted        = r_halted;
endmodule

// File: tb/tb_fetch_control.sv
// tb_fetch_control: scoreboard bench for fetch_control with a variable-latency memory responder
module tb_fetch_control;
  import fetch_control_pkg::*;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
  } exec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] o_imem_addr;
  logic        o_imem_re;
  logic [31:0] i_imem_data = '0;
  logic        i_imem_valid = 1'b0;
  logic        i_jmp_en = 1'b0;
  logic [15:0] i_jmp_addr = '0;
  logic [31:0] o_instr0;
  logic [31:0] o_instr1;
  logic [3:0]  o_current_state;
  logic [15:0] o_pc;
  logic        o_halted;

  logic [31:0] mem [0:65535];
  exec_t       exp_exec[$];
  logic [15:0] exp_req[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 1;

  localparam logic [31:0] W_CP    = {OP_CP, 24'h0000AA};
  localparam logic [31:0] W_LIMM  = {OP_LIMM32, 24'h000000};
  localparam logic [31:0] W_LIMM2 = {OP_LIMM32, 24'h0000FF};
  localparam logic [31:0] W_END   = {OP_END, 24'h000000};
  localparam logic [31:0] W_IMM   = 32'h12345678;

  fetch_control dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .o_imem_addr     (o_imem_addr),
    .o_imem_re       (o_imem_re),
    .i_imem_data     (i_imem_data),
    .i_imem_valid    (i_imem_valid),
    .i_jmp_en        (i_jmp_en),
    .i_jmp_addr      (i_jmp_addr),
    .o_instr0        (o_instr0),
    .o_instr1        (o_instr1),
    .o_current_state (o_current_state),
    .o_pc            (o_pc),
    .o_halted        (o_halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exec(input logic [15:0] pc, input logic [31:0] i0, input logic [31:0] i1);
    exec_t e;
    e.pc = pc;
    e.i0 = i0;
    e.i1 = i1;
    exp_exec.push_back(e);
  endtask

  task automatic check_reset();
    chk("rst_state", 64'(o_current_state), 64'(STATE_FETCH0));
    chk("rst_pc", 64'(o_pc), 64'h0);
    chk("rst_instr0", 64'(o_instr0), 64'h0);
    chk("rst_instr1", 64'(o_instr1), 64'h0);
    chk("rst_imem_re", 64'(o_imem_re), 64'h0);
    chk("rst_halted", 64'(o_halted), 64'h0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!o_halted && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    if (!o_halted) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout actual=%0d cycles required=halted", n);
    end
  endtask

  task automatic halt_hold();
    repeat (8) begin
      @(posedge clk);
      #1 chk("halt_hold", 64'({o_halted, o_imem_re, o_current_state}), 64'({1'b1, 1'b0, 4'(STATE_HLT)}));
    end
  endtask

  // memory: latches the request address when re is seen and answers lat negedges later, even across a reset
  initial begin
    logic        pending;
    int          cnt;
    logic [15:0] paddr;
    pending = 1'b0;
    cnt = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      if (!pending && o_imem_re && !i_imem_valid) begin
        pending = 1'b1;
        cnt = lat;
        paddr = o_imem_addr;
      end
      i_imem_valid = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          pending = 1'b0;
          i_imem_valid = 1'b1;
          i_imem_data = mem[paddr];
        end
      end
    end
  end

  // monitor: pops the scoreboard on every EXEC cycle and every new read request
  initial begin
    exec_t       e;
    logic [15:0] a;
    logic        prev_re;
    logic [15:0] prev_addr;
    logic [31:0] prev_i0;
    prev_re = 1'b0;
    prev_addr = '0;
    prev_i0 = '0;
    forever begin
      @(negedge clk);
      if (o_current_state == 4'(STATE_EXEC)) begin
        if (exp_exec.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exec_unexpected actual=pc %0h required=no exec", o_pc);
        end else begin
          e = exp_exec.pop_front();
          chk("exec_pc", 64'(o_pc), 64'(e.pc));
          chk("exec_instr0", 64'(o_instr0), 64'(e.i0));
          chk("exec_instr1", 64'(o_instr1), 64'(e.i1));
        end
      end
      if (o_imem_re && !prev_re) begin
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected actual=addr %0h required=no request", o_imem_addr);
        end else begin
          a = exp_req.pop_front();
          chk("req_addr", 64'(o_imem_addr), 64'(a));
        end
      end
      if (o_imem_re && prev_re) begin
        chk("addr_hold", 64'(o_imem_addr), 64'(prev_addr));
        chk("instr0_hold", 64'(o_instr0), 64'(prev_i0));
      end
      prev_re = o_imem_re;
      prev_addr = o_imem_addr;
      prev_i0 = o_instr0;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[0] = W_CP;
    mem[1] = W_LIMM;
    mem[2] = W_IMM;
    mem[3] = W_END;
    mem[16'h0040] = W_END;
    mem[16'hFFFF] = W_LIMM2;

    // run 1: CP, LIMM32 + immediate, END with one-cycle memory
    lat = 1;
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0001);
    exp_req.push_back(16'h0002);
    exp_req.push_back(16'h0003);
    push_exec(16'h0000, W_CP, 32'h0);
    push_exec(16'h0001, W_LIMM, W_IMM);
    push_exec(16'h0003, W_END, 32'h0);
    reset_pulse();
    wait_halt(n);
    chk("run1_cycles", 64'(n), 64'd11);
    i_jmp_en = 1'b1;
    i_jmp_addr = 16'h0000;
    halt_hold();

    // run 2: branch from the first EXEC to 0x0040, END there with jmp_en still high
    i_jmp_addr = 16'h0040;
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0040);
    push_exec(16'h0000, W_CP, 32'h0);
    push_exec(16'h0040, W_END, 32'h0);
    reset_pulse();
    wait_halt(n);
    halt_hold();

    // run 3: four-cycle memory, branch to 0xFFFF, LIMM32 wraps, reset during the next wait
    lat = 4;
    i_jmp_addr = 16'hFFFF;
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'hFFFF);
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0001);
    push_exec(16'h0000, W_CP, 32'h0);
    push_exec(16'hFFFF, W_LIMM2, W_CP);
    reset_pulse();
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (o_current_state != 4'(STATE_EXEC) && n < 100);
    @(posedge clk);
    #1 i_jmp_en = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!(o_imem_re && o_imem_addr == 16'h0001) && n < 100);
    chk("wrap_fetch_addr1", 64'({o_imem_re, o_imem_addr}), 64'({1'b1, 16'h0001}));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset();
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0001);
    exp_req.push_back(16'h0002);
    exp_req.push_back(16'h0003);
    push_exec(16'h0000, W_CP, 32'h0);
    push_exec(16'h0001, W_LIMM, W_IMM);
    push_exec(16'h0003, W_END, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_halt(n);
    halt_hold();

    chk("exec_queue_empty", 64'(exp_exec.size()), 64'd0);
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
